bus_transfer_sequencer: RTL and testbench
=========================================

# bus_transfer_sequencer

Sequences register-to-register moves over the shared 16-bit datapath bus on behalf of two requesters: the control unit (requester 0) and an auxiliary master such as a DMA or microcode engine (requester 1). The block arbitrates, accepts one transfer descriptor at a time, and drives the bus source-select code and destination-select code in the two consecutive cycles the bus needs: source latch, then destination capture. It sits between the requesters and the bus select inputs, and is the only driver of those selects.

## Interface
Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin between requesters; 1 = requester 0 always wins a tie.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 presents a transfer.
- req0_src  input  4  requester 0 bus source code.
- req0_dst  input  3  requester 0 bus destination code.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req1_valid, req1_src, req1_dst, req1_ready  same widths and meaning, for requester 1.
- select_source  output  4  bus source select; 4'b0000 = hold.
- select_destination  output  3  bus destination select; 3'b000 = none.
- busy  output  1  a transfer is in flight (state SRC or DST).
- done  output  1  one-cycle pulse: the accepted transfer is complete.
- done_id  output  1  requester that owns the completing transfer; valid while done=1.
- error  output  1  one-cycle pulse: an illegal descriptor was dropped (see Configuration).

## Operation
- States: IDLE, SRC, DST.
- IDLE: the arbiter selects a requester. reqN_ready = (state==IDLE) && (grant==N); combinational from valid and the pointer. A handshake occurs when valid && ready at a rising edge. The descriptor is latched into src_q, dst_q, and id_q.
- Arbitration: if only one request is valid, it is granted. If both are valid, the request selected by the priority pointer is granted. The pointer resets to 0 and flips to the non-granted requester after each handshake. With FIXED_PRIORITY=1, the pointer is held at 0.
- After handshake:
  - src_q!=0000 goes to SRC.
  - src_q==0000 && dst_q!=000 goes to DST.
  - Both zero (NOP) returns to IDLE, and done pulses next cycle.
- SRC: select_source=src_q, select_destination=000. Next state is DST if dst_q!=000, otherwise IDLE.
- DST: select_source=0000, select_destination=dst_q. Next state is IDLE.
- done and done_id are registered. They are asserted in the cycle following the last SRC/DST cycle. That cycle is IDLE, so a new handshake may coincide with done.
- In IDLE, select_source=0000 and select_destination=000.
- Reset values (reset_n low, asynchronous): state IDLE, pointer 0, select_source 0000, select_destination 000, busy 0, done 0, done_id 0, error 0, both ready 0 while reset asserted.
- Reset mid-transfer: the transfer is dropped with no done. Selects return to zero immediately, not at the next edge.
- Descriptor inputs are ignored outside the handshake edge. A requester may change or drop valid while not ready.

## Timing
- Handshake at edge E0. SRC occupies E0–E1, DST occupies E1–E2, and done is high E2–E3.
- Full transfer latency is 3 cycles from handshake to done. A source-only or destination-only transfer takes 2 cycles. A NOP takes 1 cycle.
- Peak throughput is one full transfer per 3 cycles, with back-to-back handshakes at E2.
- All outputs except reqN_ready are registered.

## Configuration
- BUS_SEQ_CHECK_EN defined:
  - Legal source codes are 0000–0011 and 0101–1011. Legal destination codes are 000, 010, 011, and 110.
  - A descriptor with any illegal code is still handshaken but is not issued. The state returns to IDLE, and error pulses (instead of done) in the next cycle, with done_id set to the requester.
- BUS_SEQ_CHECK_EN undefined: codes pass through unchecked, and error is tied to 0.

## Test plan
- Reset, then req0 with src=0001, dst=010. Expect: ready0=1 at E0; SRC cycle with select_source=0001; DST cycle with select_destination=010; done=1, done_id=0 at E2–E3; busy high for 2 cycles.
- Both valid continuously, round-robin. Expect grants alternating 0,1,0,1 and handshakes every 3 cycles. With FIXED_PRIORITY=1, expect requester 0 granted every time.
- req1 with src=0101, dst=000. Expect a single SRC cycle, then done at the next cycle. Then src=0000, dst=110: expect a single DST cycle with select_destination=110.
- NOP: req0 with src=0000, dst=000. Expect done one cycle after the handshake, with no nonzero select ever driven.
- Assert reset_n low during the DST cycle of a transfer. Expect the selects to be zero immediately, no done, and the next transfer after release to be granted by requester 0.
- With BUS_SEQ_CHECK_EN: req0 with src=1100, dst=010. Expect handshake, no select activity, error=1, done=0 on the next cycle. Without the macro, expect select_source=1100 to be issued.

Source files
------------

// File: rtl/bus_transfer_sequencer.sv
// rtl/bus_transfer_sequencer.sv - two-requester bus move sequencer (optional BUS_SEQ_CHECK_EN code legality check)
module bus_transfer_sequencer #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_src,
    input  logic [2:0] req0_dst,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_src,
    input  logic [2:0] req1_dst,
    output logic       req1_ready,
    output logic [3:0] select_source,
    output logic [2:0] select_destination,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       error
);

    typedef enum logic [1:0] {IDLE, SRC, DST} state_t;

    state_t     state;
    logic       ptr;
    logic [2:0] dst_q;
    logic       id_q;
    logic       grant;
    logic       hs;
    logic [3:0] hs_src;
    logic [2:0] hs_dst;
    logic       legal;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ptr;
        else if (req1_valid)          grant = 1'b1;
    end

    // Ready is forced low while reset is asserted, even though state already reads IDLE.
    assign req0_ready = reset_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = reset_n && (state == IDLE) && req1_valid && grant;
    assign hs         = req0_ready || req1_ready;
    assign hs_src     = grant ? req1_src : req0_src;
    assign hs_dst     = grant ? req1_dst : req0_dst;

`ifdef BUS_SEQ_CHECK_EN
    logic err_q;

    assign legal = (hs_src != 4'b0100) && (hs_src <= 4'b1011) &&
                   ((hs_dst == 3'b000) || (hs_dst == 3'b010) ||
                    (hs_dst == 3'b011) || (hs_dst == 3'b110));
    assign error = err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= hs && !legal;
    end
`else
    assign legal = 1'b1;
    assign error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            ptr                <= 1'b0;
            dst_q              <= 3'b000;
            id_q               <= 1'b0;
            select_source      <= 4'b0000;
            select_destination <= 3'b000;
            busy               <= 1'b0;
            done               <= 1'b0;
            done_id            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        id_q  <= grant;
                        dst_q <= hs_dst;
                        if (FIXED_PRIORITY == 0) ptr <= ~grant;
                        if (!legal) begin
                            done_id <= grant;
                        end else if (hs_src != 4'b0000) begin
                            state         <= SRC;
                            select_source <= hs_src;
                            busy          <= 1'b1;
                        end else if (hs_dst != 3'b000) begin
                            state              <= DST;
                            select_destination <= hs_dst;
                            busy               <= 1'b1;
                        end else begin
                            done    <= 1'b1;
                            done_id <= grant;
                        end
                    end
                end
                SRC: begin
                    select_source <= 4'b0000;
                    if (dst_q != 3'b000) begin
                        state              <= DST;
                        select_destination <= dst_q;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        done_id <= id_q;
                    end
                end
                DST: begin
                    state              <= IDLE;
                    select_destination <= 3'b000;
                    busy               <= 1'b0;
                    done               <= 1'b1;
                    done_id            <= id_q;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb/tb_bus_transfer_sequencer.sv - directed self-checking bench for bus_transfer_sequencer
module tb_bus_transfer_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_src, req1_src;
    logic [2:0] req0_dst, req1_dst;

    logic       a_r0, a_r1, a_busy, a_done, a_id, a_err;
    logic [3:0] a_ss;
    logic [2:0] a_sd;
    logic       b_r0, b_r1, b_busy, b_done, b_id, b_err;
    logic [3:0] b_ss;
    logic [2:0] b_sd;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    bus_transfer_sequencer #(.FIXED_PRIORITY(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_src(req0_src), .req0_dst(req0_dst), .req0_ready(a_r0),
        .req1_valid(req1_valid), .req1_src(req1_src), .req1_dst(req1_dst), .req1_ready(a_r1),
        .select_source(a_ss), .select_destination(a_sd), .busy(a_busy),
        .done(a_done), .done_id(a_id), .error(a_err)
    );

    bus_transfer_sequencer #(.FIXED_PRIORITY(1)) dut_fixed (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_src(req0_src), .req0_dst(req0_dst), .req0_ready(b_r0),
        .req1_valid(req1_valid), .req1_src(req1_src), .req1_dst(req1_dst), .req1_ready(b_r1),
        .select_source(b_ss), .select_destination(b_sd), .busy(b_busy),
        .done(b_done), .done_id(b_id), .error(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic v0, input logic [3:0] s0, input logic [2:0] d0,
                           input logic v1, input logic [3:0] s1, input logic [2:0] d1);
        req0_valid = v0; req0_src = s0; req0_dst = d0;
        req1_valid = v1; req1_src = s1; req1_dst = d1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_req(1'b1, 4'h1, 3'd2, 1'b0, 4'h0, 3'd0);
        #2;
        check("rst_ss", a_ss, 4'h0);
        check("rst_sd", a_sd, 3'd0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_id", a_id, 1'b0);
        check("rst_err", a_err, 1'b0);
        check("rst_ready0", a_r0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        // full transfer from requester 0
        check("t1_ready0", a_r0, 1'b1);
        check("t1_ready1", a_r1, 1'b0);
        tick();
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        check("t1_src_ss", a_ss, 4'h1);
        check("t1_src_sd", a_sd, 3'd0);
        check("t1_src_busy", a_busy, 1'b1);
        tick();
        check("t1_dst_ss", a_ss, 4'h0);
        check("t1_dst_sd", a_sd, 3'd2);
        check("t1_dst_busy", a_busy, 1'b1);
        check("t1_dst_done", a_done, 1'b0);
        tick();
        check("t1_done", a_done, 1'b1);
        check("t1_done_id", a_id, 1'b0);
        check("t1_idle_busy", a_busy, 1'b0);
        check("t1_idle_sd", a_sd, 3'd0);
        tick();
        check("t1_done_pulse", a_done, 1'b0);

        // round-robin vs fixed priority, both valid continuously
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        set_req(1'b1, 4'h1, 3'd2, 1'b1, 4'h3, 3'd3);
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("rr_ready0_c%0d", c), a_r0, (c % 3 == 0) && ((c / 3) % 2 == 0));
            check($sformatf("rr_ready1_c%0d", c), a_r1, (c % 3 == 0) && ((c / 3) % 2 == 1));
            check($sformatf("fx_ready0_c%0d", c), b_r0, (c % 3 == 0));
            check($sformatf("fx_ready1_c%0d", c), b_r1, 1'b0);
            if (c % 3 == 0 && c >= 3) begin
                check($sformatf("rr_done_c%0d", c), a_done, 1'b1);
                check($sformatf("rr_id_c%0d", c), a_id, ((c / 3) - 1) % 2);
                check($sformatf("fx_id_c%0d", c), b_id, 1'b0);
            end
            tick();
        end
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        check("rr_last_done", a_done, 1'b1);
        check("rr_last_id", a_id, 1'b1);
        tick();

        // source-only then destination-only from requester 1
        set_req(1'b0, 4'h0, 3'd0, 1'b1, 4'h5, 3'd0);
        #1;
        check("so_ready1", a_r1, 1'b1);
        tick();
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        check("so_ss", a_ss, 4'h5);
        check("so_sd", a_sd, 3'd0);
        tick();
        check("so_done", a_done, 1'b1);
        check("so_id", a_id, 1'b1);
        check("so_ss_idle", a_ss, 4'h0);
        check("so_sd_idle", a_sd, 3'd0);
        set_req(1'b0, 4'h0, 3'd0, 1'b1, 4'h0, 3'd6);
        #1;
        check("do_ready1", a_r1, 1'b1);
        tick();
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        check("do_ss", a_ss, 4'h0);
        check("do_sd", a_sd, 3'd6);
        check("do_busy", a_busy, 1'b1);
        tick();
        check("do_done", a_done, 1'b1);
        check("do_id", a_id, 1'b1);
        check("do_sd_idle", a_sd, 3'd0);
        tick();

        // NOP
        set_req(1'b1, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        #1;
        check("nop_ready0", a_r0, 1'b1);
        tick();
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        check("nop_done", a_done, 1'b1);
        check("nop_id", a_id, 1'b0);
        check("nop_ss", a_ss, 4'h0);
        check("nop_sd", a_sd, 3'd0);
        check("nop_busy", a_busy, 1'b0);
        tick();
        check("nop_done_pulse", a_done, 1'b0);

        // reset during DST; pointer now favours requester 1 until reset
        set_req(1'b1, 4'h2, 3'd3, 1'b0, 4'h0, 3'd0);
        tick();
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        tick();
        check("mr_dst_sd", a_sd, 3'd3);
        #2;
        reset_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("mr_sd_async", a_sd, 3'd0);
        check("mr_ss_async", a_ss, 4'h0);
        check("mr_busy_async", a_busy, 1'b0);
        check("mr_ready0_rst", a_r0, 1'b0);
        tick();
        check("mr_no_done", a_done, 1'b0);
        reset_n = 1'b1;
        set_req(1'b1, 4'h1, 3'd0, 1'b1, 4'h1, 3'd0);
        #1;
        check("mr_ready0_after", a_r0, 1'b1);
        check("mr_ready1_after", a_r1, 1'b0);
        tick();
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
        tick();
        tick();

        // illegal source code
        set_req(1'b1, 4'hC, 3'd2, 1'b0, 4'h0, 3'd0);
        #1;
        check("ill_ready0", a_r0, 1'b1);
        tick();
        set_req(1'b0, 4'h0, 3'd0, 1'b0, 4'h0, 3'd0);
`ifdef BUS_SEQ_CHECK_EN
        check("ill_ss", a_ss, 4'h0);
        check("ill_busy", a_busy, 1'b0);
        check("ill_err", a_err, 1'b1);
        check("ill_done", a_done, 1'b0);
        check("ill_id", a_id, 1'b0);
        tick();
        check("ill_err_pulse", a_err, 1'b0);
`else
        check("ill_ss", a_ss, 4'hC);
        check("ill_busy", a_busy, 1'b1);
        check("ill_err", a_err, 1'b0);
        tick();
        check("ill_sd", a_sd, 3'd2);
        tick();
        check("ill_done", a_done, 1'b1);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
